fb_write_packer: RTL

//  Packs a raster-order 16-bit pixel stream from the rasterizer into cache-block-sized DRAM write bursts.

---
 rtl/fb_write_packer_if.sv | 29 ++
 rtl/fb_write_packer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fb_write_packer_if.sv
// Pixel-stream input and DRAM write-port output of the frame-buffer write packer.
// The packer uses the slave modport; the pixel source / DRAM side uses master.
interface fb_write_packer_if #(
    parameter int PIXEL_BITS       = 16,
    parameter int PIXELS_PER_BLOCK = 256,
    parameter int DRAM_ADDR_BITS   = 27
);
    logic                                   pix_valid;
    logic                                   pix_ready;
    logic [PIXEL_BITS-1:0]                  pix_data;
    logic                                   pix_sof;
    logic                                   wr_en;
    logic                                   wr_rdy;
    logic                                   wr_rq;
    logic [DRAM_ADDR_BITS-1:0]              wr_addr;
    logic [PIXEL_BITS*PIXELS_PER_BLOCK-1:0] wr_data;
    logic                                   frame_done;
    logic                                   sof_err;

    modport master (
        output pix_valid, pix_data, pix_sof, wr_en, wr_rdy,
        input  pix_ready, wr_rq, wr_addr, wr_data, frame_done, sof_err
    );

    modport slave (
        input  pix_valid, pix_data, pix_sof, wr_en, wr_rdy,
        output pix_ready, wr_rq, wr_addr, wr_data, frame_done, sof_err
    );
endinterface

// File: rtl/fb_write_packer.sv
// Packs a raster-order pixel stream into block-sized DRAM write requests.
// One block assembles while the previous one waits in the output register for the DRAM.
//
//  state | meaning
//  IDLE  | output register free; moves an assembled block in when one is ready
//  PEND  | block held on wr_addr/wr_data, waiting for wr_rdy
//  HOLD  | request issued; wr_rdy ignored until the holdoff count expires
module fb_write_packer #(
    parameter int PIXEL_BITS       = 16,
    parameter int PIXELS_PER_BLOCK = 256,
    parameter int FRAME_WIDTH      = 1024,
    parameter int FRAME_HEIGHT     = 768,
    parameter int DRAM_ADDR_BITS   = 27,
    parameter int FB_BASE          = 0,
    parameter int RDY_HOLDOFF      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    fb_write_packer_if.slave bus
);
    localparam int BLOCK_BITS = PIXEL_BITS * PIXELS_PER_BLOCK;
    localparam int IDX_W      = $clog2(PIXELS_PER_BLOCK);
    localparam int HOLD_W     = $clog2(RDY_HOLDOFF + 1);
    localparam logic [IDX_W-1:0]          IDX_LAST  = IDX_W'(PIXELS_PER_BLOCK - 1);
    localparam logic [DRAM_ADDR_BITS-1:0] PIX_LAST  = DRAM_ADDR_BITS'(FRAME_WIDTH * FRAME_HEIGHT - 1);
    localparam logic [DRAM_ADDR_BITS-1:0] BASE_A    = DRAM_ADDR_BITS'(FB_BASE);
    localparam logic [DRAM_ADDR_BITS-1:0] LAST_BLK  =
        DRAM_ADDR_BITS'(FB_BASE + FRAME_WIDTH * FRAME_HEIGHT - PIXELS_PER_BLOCK);
    localparam logic [HOLD_W-1:0]         HOLD_LOAD = HOLD_W'(RDY_HOLDOFF);

    typedef enum logic [1:0] {IDLE, PEND, HOLD} out_state_e;

    out_state_e                state_q, state_d;
    logic [BLOCK_BITS-1:0]     asm_q, asm_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [DRAM_ADDR_BITS-1:0] pix_cnt_q, pix_cnt_d;
    logic [DRAM_ADDR_BITS-1:0] blk_addr_q, blk_addr_d;
    logic                      asm_full_q, asm_full_d;
    logic                      pix_ready_q, pix_ready_d;
    logic                      wr_rq_q, wr_rq_d;
    logic [DRAM_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [BLOCK_BITS-1:0]     wr_data_q, wr_data_d;
    logic                      frame_done_q, frame_done_d;
    logic                      sof_err_q, sof_err_d;
    logic [HOLD_W-1:0]         hold_cnt_q, hold_cnt_d;

    logic                      xfer;
    logic [IDX_W-1:0]          eff_idx;
    logic [DRAM_ADDR_BITS-1:0] eff_cnt;

    always_comb begin
        state_d      = state_q;
        asm_d        = asm_q;
        idx_d        = idx_q;
        pix_cnt_d    = pix_cnt_q;
        blk_addr_d   = blk_addr_q;
        asm_full_d   = asm_full_q;
        wr_rq_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        sof_err_d    = 1'b0;
        hold_cnt_d   = hold_cnt_q;

        // pix_sof restarts both the frame position and the block, dropping any partial block
        xfer    = bus.pix_valid & pix_ready_q;
        eff_idx = bus.pix_sof ? '0 : idx_q;
        eff_cnt = bus.pix_sof ? '0 : pix_cnt_q;

        if (xfer) begin
            asm_d[eff_idx*PIXEL_BITS +: PIXEL_BITS] = bus.pix_data;
            if (eff_idx == '0) begin
                blk_addr_d = BASE_A + eff_cnt;
            end
            if (eff_idx == IDX_LAST) begin
                asm_full_d = 1'b1;
                idx_d      = '0;
            end else begin
                idx_d      = eff_idx + 1'b1;
            end
            pix_cnt_d = (eff_cnt == PIX_LAST) ? '0 : eff_cnt + 1'b1;
            sof_err_d = bus.pix_sof & (idx_q != '0);
        end

        case (state_q)
            IDLE: begin
                if (asm_full_q) begin
                    wr_data_d  = asm_q;
                    wr_addr_d  = blk_addr_q;
                    asm_full_d = 1'b0;
                    if (bus.wr_en) begin
                        state_d = PEND;
                    end else begin
                        frame_done_d = (blk_addr_q == LAST_BLK);
                    end
                end
            end
            PEND: begin
                if (bus.wr_rdy) begin
                    wr_rq_d      = 1'b1;
                    frame_done_d = (wr_addr_q == LAST_BLK);
                    hold_cnt_d   = HOLD_LOAD;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stays low one extra cycle after the hand-off so a just-freed buffer is never overwritten early
        pix_ready_d = ~(asm_full_d | asm_full_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            asm_q        <= '0;
            idx_q        <= '0;
            pix_cnt_q    <= '0;
            blk_addr_q   <= '0;
            asm_full_q   <= 1'b0;
            pix_ready_q  <= 1'b1;
            wr_rq_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            asm_q        <= asm_d;
            idx_q        <= idx_d;
            pix_cnt_q    <= pix_cnt_d;
            blk_addr_q   <= blk_addr_d;
            asm_full_q   <= asm_full_d;
            pix_ready_q  <= pix_ready_d;
            wr_rq_q      <= wr_rq_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign bus.pix_ready  = pix_ready_q;
    assign bus.wr_rq      = wr_rq_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.sof_err    = sof_err_q;
endmodule
